// File: rtl/sort_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sort_pkg                                                   |
// | Purpose : Shared types and default sizing for the bitonic sort       |
// |           pipeline: element type, read-FSM state encoding and the    |
// |           element-counter width.                                     |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package sort_pkg;

    // Default element width and vector length used across the sort steps.
    localparam int c_WIDTH = 8;
    localparam int c_INDEX = 8;

    // Width of an element position / counter within one vector.
    localparam int c_CNT_W = $clog2(c_INDEX);

    // One element of a vector, shared with the sort steps.
    typedef logic [c_WIDTH-1:0] elem_t;

    // Read-side state machine encoding.
    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/sort_drain_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sort_drain_bank                                            |
// | Purpose : One vector register bank. Captures a complete parallel     |
// |           vector on a load enable and presents one element through   |
// |           an indexed read mux.                                       |
// | Ports   : clk       - clock, rising edge                             |
// |           rst       - asynchronous reset, active low                 |
// |           i_load    - capture i_data this cycle                      |
// |           i_data    - parallel vector, element 0 first               |
// |           i_pos     - element position to read                       |
// |           o_data    - element at i_pos                               |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sort_drain_bank
    import sort_pkg::*;
#(
    parameter  int WIDTH   = c_WIDTH,
    parameter  int INDEX   = c_INDEX,
    localparam int c_POS_W = $clog2(INDEX)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [WIDTH-1:0]   i_data [0:INDEX-1],
    input  logic [c_POS_W-1:0] i_pos,
    output logic [WIDTH-1:0]   o_data
);

    logic [WIDTH-1:0] r_mem_q [0:INDEX-1];
    logic [WIDTH-1:0] w_mem_d [0:INDEX-1];

    always_comb begin
        w_mem_d = r_mem_q;
        if (i_load) begin
            w_mem_d = i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < INDEX; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_mem_q <= w_mem_d;
        end
    end

    assign o_data = r_mem_q[i_pos];

endmodule
`default_nettype wire

// File: rtl/sort_drain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sort_drain                                                 |
// | Purpose : Reader end of the bitonic sort pipeline. Captures whole    |
// |           sorted vectors into a two-bank ping-pong buffer and        |
// |           streams them out one element per cycle, ascending or       |
// |           descending as selected per vector.                         |
// | Ports   : clk       - clock, rising edge                             |
// |           rst       - asynchronous reset, active low                 |
// |           in_valid  - in_data holds a complete vector                |
// |           in_ready  - a bank is free for the next vector             |
// |           in_data   - parallel sorted vector                         |
// |           in_desc   - 1: emit element INDEX-1 first                  |
// |           out_valid - out_data is valid                              |
// |           out_ready - consumer accepts                               |
// |           out_data  - current element                                |
// |           out_idx   - array position of out_data                     |
// |           out_last  - final element of the vector                    |
// |           busy      - at least one bank holds a vector               |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sort_drain
    import sort_pkg::*;
#(
    parameter  int WIDTH   = c_WIDTH,
    parameter  int INDEX   = c_INDEX,
    localparam int c_PTR_W = $clog2(INDEX)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data [0:INDEX-1],
    input  logic               in_desc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [c_PTR_W-1:0] out_idx,
    output logic               out_last,
    output logic               busy
);

    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(INDEX - 1);

    // Registered state
    logic [1:0]         r_full_q;
    logic [1:0]         r_desc_q;
    logic               r_wr_bank_q;
    logic               r_rd_bank_q;
    logic [c_PTR_W-1:0] r_cnt_q;
    rd_state_t          r_state_q;

    // Next-state values
    logic [1:0]         w_full_d;
    logic [1:0]         w_desc_d;
    logic               w_wr_bank_d;
    logic               w_rd_bank_d;
    logic [c_PTR_W-1:0] w_cnt_d;
    rd_state_t          w_state_d;

    logic               w_accept;
    logic               w_stream;
    logic               w_xfer;
    logic               w_last;
    logic [c_PTR_W-1:0] w_pos;
    logic [WIDTH-1:0]   w_bank_data [0:1];

    // in_ready depends only on the flags (and the reset pin, so it reads 0
    // while the block is held in reset).
    assign in_ready = rst & ~r_full_q[r_wr_bank_q];
    assign w_accept = in_valid & in_ready;

    assign w_stream = (r_state_q == RD_STREAM);
    assign w_last   = w_stream & (r_cnt_q == c_LAST);
    assign w_xfer   = w_stream & out_ready;

    // Descending vectors are walked from the top element down.
    assign w_pos = r_desc_q[r_rd_bank_q] ? (c_LAST - r_cnt_q) : r_cnt_q;

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            sort_drain_bank #(
                .WIDTH (WIDTH),
                .INDEX (INDEX)
            ) u_bank (
                .clk    (clk),
                .rst    (rst),
                .i_load (w_accept && (r_wr_bank_q == 1'(b))),
                .i_data (in_data),
                .i_pos  (w_pos),
                .o_data (w_bank_data[b])
            );
        end
    endgenerate

    always_comb begin
        w_full_d    = r_full_q;
        w_desc_d    = r_desc_q;
        w_wr_bank_d = r_wr_bank_q;
        w_rd_bank_d = r_rd_bank_q;
        w_cnt_d     = r_cnt_q;
        w_state_d   = r_state_q;

        if (w_accept) begin
            w_full_d[r_wr_bank_q] = 1'b1;
            w_desc_d[r_wr_bank_q] = in_desc;
            w_wr_bank_d           = ~r_wr_bank_q;
        end

        case (r_state_q)
            RD_IDLE: begin
                if (r_full_q[r_rd_bank_q]) begin
                    w_state_d = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_full_d[r_rd_bank_q] = 1'b0;
                        w_rd_bank_d           = ~r_rd_bank_q;
                        w_cnt_d               = '0;
                        // Look at the updated flags so a vector captured in
                        // this same cycle follows without an idle cycle.
                        w_state_d = w_full_d[~r_rd_bank_q] ? RD_STREAM : RD_IDLE;
                    end else begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full_q    <= '0;
            r_desc_q    <= '0;
            r_wr_bank_q <= 1'b0;
            r_rd_bank_q <= 1'b0;
            r_cnt_q     <= '0;
            r_state_q   <= RD_IDLE;
        end else begin
            r_full_q    <= w_full_d;
            r_desc_q    <= w_desc_d;
            r_wr_bank_q <= w_wr_bank_d;
            r_rd_bank_q <= w_rd_bank_d;
            r_cnt_q     <= w_cnt_d;
            r_state_q   <= w_state_d;
        end
    end

    assign out_valid = w_stream;
    assign out_data  = w_stream ? w_bank_data[r_rd_bank_q] : '0;
    assign out_idx   = w_stream ? w_pos : '0;
    assign out_last  = w_last;
    assign busy      = r_full_q[0] | r_full_q[1];

endmodule
`default_nettype wire

// File: tb/tb_sort_drain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_sort_drain                                              |
// | Purpose : Directed self-checking bench for sort_drain.               |
// | Ports   : none                                                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_sort_drain;

    localparam int c_W = 8;
    localparam int c_N = 8;

    typedef logic [c_W-1:0] vec_t [0:c_N-1];

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    vec_t       in_data;
    logic       in_desc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_idx;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int errors = 0;

    vec_t va = '{8'd3, 8'd7, 8'd9, 8'd12, 8'd20, 8'd33, 8'd40, 8'd90};
    vec_t vb = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
    vec_t vc = '{8'd100, 8'd101, 8'd102, 8'd103, 8'd104, 8'd105, 8'd106, 8'd107};
    vec_t vd = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128};
    vec_t vz = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    sort_drain #(
        .WIDTH (c_W),
        .INDEX (c_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a full vector to stream with out_ready held high.
    // raise_at: raise in_valid before the tick of that element.
    // drop_at : drop in_valid after the tick of that element.
    task automatic drain(input string tag, input logic desc, input vec_t v,
                         input int raise_at, input int drop_at);
        for (int k = 0; k < c_N; k++) begin
            int p;
            p = desc ? (c_N - 1 - k) : k;
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_data"},  out_data,  v[p]);
            chk({tag, "_idx"},   out_idx,   p);
            chk({tag, "_last"},  out_last,  (k == c_N - 1));
            if (k == raise_at) in_valid = 1'b1;
            tick();
            if (k == drop_at) in_valid = 1'b0;
        end
    endtask

    // Pattern for the backpressure test: ready 1,1,1,0,0,1,...
    logic pat [0:11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                         1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        int e;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_desc   = 1'b0;
        in_data   = vz;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_idx",   out_idx,   0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_busy",      busy,      0);
        tick();
        tick();
        rst = 1'b0;
        #1 rst = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // ---------------- ascending vector ----------------
        in_data   = va;
        in_desc   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();                       // capture edge
        in_valid = 1'b0;
        chk("asc_idle_valid", out_valid, 0);
        chk("asc_busy",       busy,      1);
        tick();
        drain("asc", 1'b0, va, -1, -1);
        chk("asc_end_valid", out_valid, 0);
        chk("asc_end_busy",  busy,      0);

        // ---------------- descending vector ----------------
        in_desc  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_desc  = 1'b0;
        chk("desc_idle_valid", out_valid, 0);
        tick();
        drain("desc", 1'b1, va, -1, -1);
        chk("desc_end_valid", out_valid, 0);

        // ---------------- both banks full ----------------
        out_ready = 1'b0;
        in_data   = va;
        in_valid  = 1'b1;
        tick();
        chk("full_rdy_after_1", in_ready, 1);
        in_data = vb;
        tick();
        chk("full_rdy_after_2", in_ready,  0);
        chk("full_busy",        busy,      1);
        chk("full_out_valid",   out_valid, 1);
        chk("full_hold_data0",  out_data,  va[0]);
        in_data = vc;
        tick();
        chk("full_rdy_held",    in_ready, 0);
        chk("full_hold_data1",  out_data, va[0]);
        chk("full_hold_idx",    out_idx,  0);
        tick();
        chk("full_hold_data2",  out_data, va[0]);
        out_ready = 1'b1;
        drain("bb_a", 1'b0, va, -1, -1);
        chk("freed_rdy", in_ready, 1);
        drain("bb_b", 1'b0, vb, -1, 0);   // third vector accepted on first tick
        drain("bb_c", 1'b0, vc, -1, -1);
        chk("bb_end_valid", out_valid, 0);
        chk("bb_end_busy",  busy,      0);

        // ---------------- backpressure mid-vector ----------------
        in_data  = vd;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        e = 0;
        for (int c = 0; c < 12; c++) begin
            if (e < c_N) begin
                chk("bp_valid", out_valid, 1);
                chk("bp_data",  out_data,  vd[e]);
                chk("bp_idx",   out_idx,   e);
                chk("bp_last",  out_last,  (e == c_N - 1));
                out_ready = pat[c];
                if (pat[c]) e++;
                tick();
            end
        end
        out_ready = 1'b1;
        chk("bp_count",     e,         c_N);
        chk("bp_end_valid", out_valid, 0);

        // ---------------- accept during final transfer ----------------
        in_data  = va;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = vb;
        tick();
        drain("ovl_a", 1'b0, va, 7, 7);
        drain("ovl_b", 1'b0, vb, -1, -1);
        chk("ovl_end_valid", out_valid, 0);
        chk("ovl_end_busy",  busy,      0);

        // ---------------- async reset mid-vector ----------------
        in_data  = vc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("ar_pre_data", out_data, vc[k]);
            tick();
        end
        chk("ar_elem4", out_data, vc[4]);
        #2 rst = 1'b0;
        #1;
        chk("ar_valid",    out_valid, 0);
        chk("ar_data",     out_data,  0);
        chk("ar_busy",     busy,      0);
        chk("ar_in_ready", in_ready,  0);
        tick();
        #2 rst = 1'b1;
        tick();
        chk("ar_post_rdy", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            chk("ar_post_valid", out_valid, 0);
            chk("ar_post_busy",  busy,      0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
